// File: rtl/start_scheduler.sv
// start_scheduler: queued start-event scheduler on the usec time base.
// A FIFO of absolute fire times feeds a compare register. When usec reaches
// the armed time, a fixed-width start pulse is emitted and the next entry is
// armed. Late entries (time already passed) are counted and dropped.
// Optional feature macro: START_SCHED_LATE_FIRE_EN. When defined, late
// entries fire immediately instead of being dropped. They are still counted.
module start_scheduler #(
    parameter int DEPTH     = 8,
    parameter int PULSE_LEN = 21,
    parameter int TW        = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TW-1:0]            usec,
    input  logic                     wr_en,
    input  logic [TW-1:0]            wr_time,
    input  logic                     flush,
    output logic                     start,
    output logic                     armed,
    output logic [TW-1:0]            cmp_time,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic [7:0]               late_cnt
);

    localparam int AW = $clog2(DEPTH);

    // state   | meaning
    // S_IDLE  | nothing armed; pops the FIFO head when one is queued
    // S_ARM   | entry in compare register, waiting for usec to reach it
    // S_LATE  | armed entry was already in the past; dropped this cycle
    // S_PULSE | start held high for PULSE_LEN cycles
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_LATE, S_PULSE} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   mem_q [DEPTH];
    logic [TW-1:0]   mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [TW-1:0]   cmp_time_q, cmp_time_d;
    logic            armed_q, armed_d;
    logic            start_q, start_d;
    logic [7:0]      pulse_cnt_q, pulse_cnt_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      late_cnt_q, late_cnt_d;

    logic            pop, push_ok, full_w, d_zero, d_past;
    logic [TW-1:0]   diff;

    // Pop and push qualification plus the modulo time difference.
    always_comb begin
        full_w  = (count_q == (AW+1)'(DEPTH));
        pop     = (state_q == S_IDLE) && (count_q != '0);
        push_ok = wr_en && (!full_w || pop);
        diff    = usec - cmp_time_q;
        d_zero  = (diff == '0);
        // Sign bit clear and nonzero: the armed time is already behind usec.
        d_past  = !diff[TW-1] && !d_zero;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmp_time_q  <= '0;
            armed_q     <= 1'b0;
            start_q     <= 1'b0;
            pulse_cnt_q <= '0;
            ovf_q       <= 1'b0;
            late_cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmp_time_q  <= cmp_time_d;
            armed_q     <= armed_d;
            start_q     <= start_d;
            pulse_cnt_q <= pulse_cnt_d;
            ovf_q       <= ovf_d;
            late_cnt_q  <= late_cnt_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (pop) state_d = S_ARM;
            S_ARM: begin
                if (d_zero) begin
                    state_d = S_PULSE;
                end else if (d_past) begin
`ifdef START_SCHED_LATE_FIRE_EN
                    state_d = S_PULSE;
`else
                    state_d = S_LATE;
`endif
                end
            end
            S_LATE:  state_d = S_IDLE;
            S_PULSE: if (pulse_cnt_q == 8'd0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // FIFO, compare register, pulse timer and status counters.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        cmp_time_d  = cmp_time_q;
        armed_d     = armed_q;
        start_d     = start_q;
        pulse_cnt_d = pulse_cnt_q;
        ovf_d       = ovf_q;
        late_cnt_d  = late_cnt_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            cmp_time_d  = '0;
            armed_d     = 1'b0;
            start_d     = 1'b0;
            pulse_cnt_d = '0;
            ovf_d       = 1'b0;
            late_cnt_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wr_time;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (wr_en && !push_ok) ovf_d = 1'b1;
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + 1'b1;
                cmp_time_d = mem_q[rd_ptr_q];
                armed_d    = 1'b1;
            end
            count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
            unique case (state_q)
                S_ARM: begin
                    if (d_past && late_cnt_q != 8'hFF) late_cnt_d = late_cnt_q + 8'd1;
`ifdef START_SCHED_LATE_FIRE_EN
                    if (d_zero || d_past) begin
                        start_d     = 1'b1;
                        pulse_cnt_d = 8'(PULSE_LEN - 1);
                    end
`else
                    if (d_zero) begin
                        start_d     = 1'b1;
                        pulse_cnt_d = 8'(PULSE_LEN - 1);
                    end else if (d_past) begin
                        armed_d    = 1'b0;
                        cmp_time_d = '0;
                    end
`endif
                end
                S_PULSE: begin
                    if (pulse_cnt_q == 8'd0) begin
                        start_d    = 1'b0;
                        armed_d    = 1'b0;
                        cmp_time_d = '0;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign start    = start_q;
    assign armed    = armed_q;
    assign cmp_time = cmp_time_q;
    assign count    = count_q;
    assign full     = full_w;
    assign empty    = (count_q == '0);
    assign ovf      = ovf_q;
    assign late_cnt = late_cnt_q;

endmodule

// File: tb/tb_start_scheduler.sv
// Bench for start_scheduler: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_start_scheduler;

    localparam int DEPTH     = 8;
    localparam int PULSE_LEN = 21;
    localparam int TW        = 32;

    logic            clk = 1'b0;
    logic            rst, wr_en, flush;
    logic [TW-1:0]   usec, wr_time;
    logic            start, armed, full, empty, ovf;
    logic [TW-1:0]   cmp_time;
    logic [3:0]      count;
    logic [7:0]      late_cnt;

    int errors = 0;
    int checks = 0;

    start_scheduler #(.DEPTH(DEPTH), .PULSE_LEN(PULSE_LEN), .TW(TW)) dut (
        .clk(clk), .rst(rst), .usec(usec), .wr_en(wr_en), .wr_time(wr_time),
        .flush(flush), .start(start), .armed(armed), .cmp_time(cmp_time),
        .count(count), .full(full), .empty(empty), .ovf(ovf), .late_cnt(late_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending times plus the armed entry,
    // the remaining pulse length and a one-cycle recovery after a late drop.
    logic [TW-1:0] m_q[$];
    logic          m_armed, m_start, m_ovf;
    logic [TW-1:0] m_cmp;
    int            m_left, m_cool;
    logic [7:0]    m_late;
    bit            started = 0;

    task automatic model_step();
        bit            pop;
        logic [TW-1:0] dd;
        if (rst || flush) begin
            m_q.delete();
            m_armed = 0; m_start = 0; m_cmp = '0; m_left = 0; m_cool = 0;
            m_ovf = 0; m_late = 0;
        end else begin
            pop = !m_armed && !m_start && m_cool == 0 && m_q.size() > 0;
            if (m_cool > 0) begin
                m_cool--;
            end else if (m_start) begin
                if (m_left == 1) begin
                    m_start = 0; m_armed = 0; m_cmp = '0;
                end else m_left--;
            end else if (m_armed) begin
                dd = usec - m_cmp;
                if (dd == 0) begin
                    m_start = 1; m_left = PULSE_LEN;
                end else if ($signed(dd) > 0) begin
                    if (m_late != 8'hFF) m_late++;
`ifdef START_SCHED_LATE_FIRE_EN
                    m_start = 1; m_left = PULSE_LEN;
`else
                    m_armed = 0; m_cmp = '0; m_cool = 1;
`endif
                end
            end else if (pop) begin
                m_cmp = m_q[0];
                m_armed = 1;
            end
            if (wr_en) begin
                if (m_q.size() < DEPTH || pop) m_q.push_back(wr_time);
                else m_ovf = 1;
            end
            if (pop) m_q.pop_front();
        end
        started = 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, plus rise and high-time counters.
    int   rises = 0;
    int   pulse_hi = 0;
    logic prev_start = 1'b0;
    logic [48:0] act_v, exp_v;

    initial forever begin
        @(negedge clk);
        if (started) begin
            act_v = {start, armed, cmp_time, count, full, empty, ovf, late_cnt};
            exp_v = {m_start, m_armed, m_cmp, 4'(m_q.size()),
                     (m_q.size() == DEPTH), (m_q.size() == 0), m_ovf, m_late};
            chk("cycle{start,armed,cmp,count,full,empty,ovf,late}", 64'(act_v), 64'(exp_v));
            if (start === 1'b1) pulse_hi++;
            if (start === 1'b1 && prev_start !== 1'b1) rises++;
            prev_start = start;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [TW-1:0] t);
        wr_en = 1; wr_time = t;
        tick(1);
        wr_en = 0;
    endtask

    initial begin
        rst = 1; flush = 0; wr_en = 0; wr_time = '0; usec = 32'd990;
        tick(3);
        chk("reset_armed", 64'(armed), 0);
        chk("reset_empty", 64'(empty), 1);
        chk("reset_count", 64'(count), 0);
        rst = 0;
        tick(1);

        // Single event at 1000.
        push(32'd1000);
        tick(1);
        chk("t1_armed", 64'(armed), 1);
        chk("t1_cmp", 64'(cmp_time), 1000);
        for (int u = 991; u < 1000; u++) begin
            usec = u; tick(2);
        end
        pulse_hi = 0;
        usec = 32'd1000;
        chk("t1_start_before", 64'(start), 0);
        tick(1);
        chk("t1_start_rise", 64'(start), 1);
        tick(20);
        chk("t1_start_last", 64'(start), 1);
        tick(1);
        chk("t1_start_fall", 64'(start), 0);
        chk("t1_disarm", 64'(armed), 0);
        tick(3);
        chk("t1_width", 64'(pulse_hi), 21);

        // Burst of three.
        usec = 32'd1999;
        push(32'd2000); push(32'd2001); push(32'd2002);
        tick(1);
        chk("t2_count_init", 64'(count), 2);
        pulse_hi = 0;
        usec = 32'd2000; tick(30);
        chk("t2_count_a", 64'(count), 1);
        usec = 32'd2001; tick(30);
        chk("t2_count_b", 64'(count), 0);
        usec = 32'd2002; tick(30);
        chk("t2_rises", 64'(rises), 4);
        chk("t2_width", 64'(pulse_hi), 63);
        chk("t2_late", 64'(late_cnt), 0);

        // Late entry.
        usec = 32'd100;
        push(32'd5);
        tick(30);
        chk("t3_late", 64'(late_cnt), 1);
`ifdef START_SCHED_LATE_FIRE_EN
        chk("t3_rises", 64'(rises), 5);
`else
        chk("t3_rises", 64'(rises), 4);
`endif
        chk("t3_disarm", 64'(armed), 0);

        // Wrap-around.
        usec = 32'hFFFF_FFF0;
        push(32'h0000_0005);
        tick(4);
        chk("t4_armed", 64'(armed), 1);
        chk("t4_cmp", 64'(cmp_time), 5);
        chk("t4_not_late", 64'(late_cnt), 1);
        usec = 32'hFFFF_FFFF; tick(2);
        usec = 32'h0000_0004; tick(3);
        chk("t4_wait", 64'(start), 0);
        usec = 32'h0000_0005; tick(1);
        chk("t4_fire", 64'(start), 1);
        tick(25);

        // Overflow and flush.
        usec = 32'd6000;
        push(32'd7000);
        tick(1);
        for (int i = 1; i <= 9; i++) push(32'd7000 + 32'(i));
        chk("t5_full", 64'(full), 1);
        chk("t5_count", 64'(count), 8);
        chk("t5_ovf", 64'(ovf), 1);
        flush = 1; tick(1); flush = 0;
        chk("t5_empty", 64'(empty), 1);
        chk("t5_ovf_clr", 64'(ovf), 0);
        chk("t5_disarm", 64'(armed), 0);
        chk("t5_late_clr", 64'(late_cnt), 0);

        // Flush during a pulse.
        usec = 32'd8000;
        push(32'd8100); push(32'd8101); push(32'd8102);
        tick(2);
        usec = 32'd8100;
        tick(1);
        chk("t6_fire", 64'(start), 1);
        tick(3);
        flush = 1; tick(1); flush = 0;
        chk("t6_abort", 64'(start), 0);
        chk("t6_empty", 64'(empty), 1);
        usec = 32'd8101; tick(30);
        usec = 32'd8102; tick(30);
`ifdef START_SCHED_LATE_FIRE_EN
        chk("t6_rises", 64'(rises), 7);
`else
        chk("t6_rises", 64'(rises), 6);
`endif
        chk("t6_armed", 64'(armed), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
